// File: rtl/arith_mix_pipe.sv
// Three-stage valid/ready pipeline for the increment/OR/add/AND mixer.
// Adds a wrapping output-transaction counter and a busy flag for the enclosing block.
module arith_mix_pipe #(
  parameter int WIDTH = 16,
  parameter int INC   = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] output_data,
  output logic [CNT_W-1:0] txn_count,
  output logic             busy
);

  localparam int H = WIDTH / 2;
  // Only the low half of input_data + INC is ever consumed, so add in H bits.
  localparam logic [H-1:0] INC_LO = H'(INC);

  logic             v1_q, v1_d;
  logic [H-1:0]     t0_lo_q, t0_lo_d;
  logic [H-1:0]     in_lo_q, in_lo_d;
  logic             v2_q, v2_d;
  logic [H-1:0]     t1_q, t1_d;
  logic [H-1:0]     t0b_q, t0b_d;
  logic             v3_q, v3_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             adv1, adv2, adv3;
  logic [H-1:0]     t0_lo, t1, t2, t3;
  logic             unused_hi;

  assign unused_hi = ^input_data[WIDTH-1:H];

  always_comb begin
    adv3  = !v3_q | out_ready;
    adv2  = !v2_q | adv3;
    adv1  = !v1_q | adv2;

    t0_lo = input_data[H-1:0] + INC_LO;
    t1    = t0_lo_q | in_lo_q;
    t2    = t1_q + t0b_q;
    t3    = t2 & t1_q;

    v1_d    = v1_q;
    t0_lo_d = t0_lo_q;
    in_lo_d = in_lo_q;
    v2_d    = v2_q;
    t1_d    = t1_q;
    t0b_d   = t0b_q;
    v3_d    = v3_q;
    out_d   = out_q;
    cnt_d   = cnt_q;

    if (adv1) begin
      v1_d    = in_valid;
      t0_lo_d = t0_lo;
      in_lo_d = input_data[H-1:0];
    end
    if (adv2) begin
      v2_d  = v1_q;
      t1_d  = t1;
      t0b_d = t0_lo_q;
    end
    // S3 only moves when the consumer took the held word or S3 is empty.
    if (adv3) begin
      v3_d  = v2_q;
      out_d = {t3, t2};
    end
    if (v3_q && out_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      t0_lo_q <= '0;
      in_lo_q <= '0;
      v2_q    <= 1'b0;
      t1_q    <= '0;
      t0b_q   <= '0;
      v3_q    <= 1'b0;
      out_q   <= '0;
      cnt_q   <= '0;
    end else begin
      v1_q    <= v1_d;
      t0_lo_q <= t0_lo_d;
      in_lo_q <= in_lo_d;
      v2_q    <= v2_d;
      t1_q    <= t1_d;
      t0b_q   <= t0b_d;
      v3_q    <= v3_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready    = adv1;
  assign out_valid   = v3_q;
  assign output_data = out_q;
  assign txn_count   = cnt_q;
  assign busy        = v1_q | v2_q | v3_q;

endmodule

// File: tb/tb_arith_mix_pipe.sv
// Scoreboard bench for arith_mix_pipe: a 16-bit instance for the main stream tests
// and an 8-bit instance with a 4-bit counter for the narrow-width and wrap cases.
module tb_arith_mix_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] input_data, output_data, txn_count;
  logic        rand_en, rnd_r, man_r;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  input_data8, output_data8;
  logic [3:0]  txn_count8;

  assign out_ready = rand_en ? rnd_r : man_r;

  arith_mix_pipe #(.WIDTH(16), .INC(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .input_data(input_data),
    .out_valid(out_valid), .out_ready(out_ready), .output_data(output_data),
    .txn_count(txn_count), .busy(busy)
  );

  arith_mix_pipe #(.WIDTH(8), .INC(1), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .input_data(input_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .output_data(output_data8),
    .txn_count(txn_count8), .busy(busy8)
  );

  typedef struct {
    logic [15:0] d;
    int          c;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  sb8[$];
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rnd_r = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [15:0] m16(input logic [15:0] x);
    logic [7:0] a, b, c;
    a = x[7:0] + 8'd1;
    b = a | x[7:0];
    c = b + a;
    return {c & b, c};
  endfunction

  // Monitor: pop expected word on every output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL stale_word: got 0x%0h, expected no output", output_data);
      end else begin
        e = sb.pop_front();
        chk("data", 32'(output_data), 32'(e.d));
        if (e.lat) chk("latency", 32'(cyc - e.c), 32'd3);
        chk("busy_with_out", 32'(busy), 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid8 && out_ready8) begin
      if (sb8.size() == 0) begin
        total++;
        $display("FAIL stale_word8: got 0x%0h, expected no output", output_data8);
      end else begin
        chk("data8", 32'(output_data8), 32'(sb8.pop_front()));
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic [15:0] e, input bit lat);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid   = 1'b1;
    input_data = d;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      $display("FAIL send_timeout: in_ready got 0 for 200 cycles, required 1 (word 0x%0h)", d);
    end else begin
      sb.push_back('{e, cyc, lat});
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int exp_txn);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #2;
    chk("txn_count", 32'(txn_count), 32'(exp_txn % 65536));
  endtask

  initial begin
    logic [15:0] w[5];
    logic [15:0] ex[5];
    logic [15:0] d;
    int          k, n;

    w  = '{16'h1234, 16'h0000, 16'h00FF, 16'hFFFF, 16'h0A0A};
    ex = '{16'h206A, 16'h0002, 16'hFFFF, 16'hFFFF, 16'h0216};

    rst = 1'b1; in_valid = 1'b0; input_data = '0;
    rand_en = 1'b0; man_r = 1'b1;
    in_valid8 = 1'b0; input_data8 = '0; out_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_output_data", 32'(output_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_txn", 32'(txn_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single word, no stall.
    send(16'h1234, 16'h206A, 1'b1);
    idle();
    drain(1);

    // Back-to-back, then busy must drop the cycle after the last out_valid.
    send(16'h0000, 16'h0002, 1'b1);
    send(16'h00FF, 16'hFFFF, 1'b1);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    idle();
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin n++; @(negedge clk); end
    while (out_valid && n < 40) begin n++; @(negedge clk); end
    chk("busy_after_last", 32'(busy), 32'd0);
    drain(4);

    // Stalled output: only three words fit.
    @(posedge clk); #1;
    man_r = 1'b0;
    k = 0;
    in_valid = 1'b1;
    input_data = w[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{ex[k], cyc, 1'b0});
        k++;
      end
      @(posedge clk); #1;
      if (k < 5) input_data = w[k];
    end
    chk("stall_accepts", 32'(k), 32'd3);
    @(negedge clk);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    chk("stall_data", 32'(output_data), 32'h206A);
    repeat (3) @(negedge clk);
    chk("stall_stable", 32'(output_data), 32'h206A);
    @(posedge clk); #1;
    in_valid = 1'b0;
    man_r = 1'b1;
    for (int i = k; i < 5; i++) send(w[i], ex[i], 1'b0);
    idle();
    drain(9);

    // Random valid/ready traffic.
    @(posedge clk); #1;
    rand_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      while ($urandom_range(0, 1) == 0) idle();
      d = 16'($urandom);
      send(d, m16(d), 1'b0);
    end
    idle();
    rand_en = 1'b0;
    man_r = 1'b1;
    drain(1009);

    // Reset with three words in flight and an input offered in the reset cycle.
    @(posedge clk); #1;
    man_r = 1'b0;
    send(16'h1111, m16(16'h1111), 1'b0);
    send(16'h2222, m16(16'h2222), 1'b0);
    send(16'h3333, m16(16'h3333), 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    man_r = 1'b1;
    input_data = 16'h5555;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_txn", 32'(txn_count), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_output_data", 32'(output_data), 32'd0);
    repeat (10) @(negedge clk);
    chk("mrst_busy_later", 32'(busy), 32'd0);

    // Narrow instance: WIDTH=8, CNT_W=4, 17 transfers wrap the counter to 1.
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      in_valid8   = 1'b1;
      input_data8 = (i % 2 == 1) ? 8'hFF : 8'h0A;
      @(negedge clk);
      if (in_ready8) sb8.push_back((i % 2 == 1) ? 8'hFF : 8'h26);
      else chk("w8_in_ready", 32'(in_ready8), 32'd1);
    end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    n = 0;
    while (sb8.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("w8_drain_empty", 32'(sb8.size()), 32'd0);
    @(posedge clk); #2;
    chk("w8_txn_wrap", 32'(txn_count8), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/arith_mix_pipe.md
Name: arith_mix_pipe

Overview:
- Pipelined, parametrised successor to the 16-bit combinational increment/OR/add/AND mixer.
- Width is generalised by WIDTH and the increment constant by INC.
- The datapath is split into three registered stages with valid/ready flow control, full throughput and backpressure.
- It also adds an output-transaction counter and a busy flag for the datapath block it sits in.

Parameters:
- WIDTH, 16: data width. Must be even and >= 4. H = WIDTH/2.
- INC, 1: constant added at stage 1, truncated to WIDTH bits.
- CNT_W, 16: width of the txn_count counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input_data is valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- input_data  input  WIDTH  operand.
- out_valid  output  1  output_data is valid.
- out_ready  input  1  downstream accepts output this cycle.
- output_data  output  WIDTH  result {t3, t2}.
- txn_count  output  CNT_W  number of completed output handshakes; wraps.
- busy  output  1  any pipeline stage holds valid data.

Behaviour:
- Arithmetic (all sums wrap modulo their width):
  - t0 = (input_data + INC) mod 2^WIDTH; only t0[H-1:0] is used downstream.
  - t1 = t0[H-1:0] | input_data[H-1:0].
  - t2 = (t1 + t0[H-1:0]) mod 2^H.
  - t3 = t2 & t1.
  - output_data = {t3, t2}.
- Stage S1 registers t0_lo = t0[H-1:0] and in_lo = input_data[H-1:0], plus valid v1.
- Stage S2 registers t1 and t0_lo, plus valid v2.
- Stage S3 registers output_data (t2 and t3 computed from S2 registers), plus valid v3. out_valid = v3.
- Flow control:
  - adv3 = !v3 | out_ready.
  - adv2 = !v2 | adv3.
  - adv1 = !v1 | adv2.
  - in_ready = adv1.
  - The combinational ready path from out_ready to in_ready is permitted.
- Stage k loads its data and valid from the previous stage when adv_k is 1; otherwise it holds.
- S1 loads valid = in_valid & in_ready.
- Bubbles are allowed to collapse: a stalled pipeline with empty stages still accepts input.
- Data registers of a stage whose incoming valid is 0 may load don't-care values.
  - output_data must stay stable while out_valid=1 and out_ready=0.
- Latency: a word accepted in cycle N is presented with out_valid=1 in cycle N+3 when there is no stall.
- Throughput is one word per cycle when out_ready is held high.
- Handshake rules:
  - A transfer occurs on in_valid & in_ready, or on out_valid & out_ready.
  - Words leave in order; none are dropped or duplicated under any in_valid/out_ready pattern.
  - in_valid asserted while in_ready=0: no transfer. The source must hold its data.
- txn_count increments by 1 on each out_valid & out_ready and wraps from 2^CNT_W-1 to 0.
- busy = v1 | v2 | v3.
- Reset (rst=1 at a clock edge):
  - v1, v2, v3 = 0; all data registers = 0; txn_count = 0.
  - Therefore out_valid=0, output_data=0, busy=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-stream discards all in-flight words. An input handshake in the reset cycle is ignored.
- Simultaneous output handshake and input accept in a full pipeline: all stages shift and the pipeline remains full.

Test Plan:
- Single word 0x1234, WIDTH=16, INC=1, out_ready=1 -> output_data=0x206A with out_valid=1 exactly 3 cycles after accept; txn_count=1.
- Back-to-back 0x0000, 0x00FF, 0xFFFF with out_ready=1 -> outputs 0x0002, 0xFFFF, 0xFFFF on consecutive cycles; busy falls 1 cycle after the last out_valid.
- Hold out_ready=0 and stream 5 words -> exactly 3 accepted, then in_ready=0 with output_data stable. Release out_ready -> all 5 words emerge in order with no loss.
- Random in_valid/out_ready (50% each), 1000 words -> in-order match against the reference model; txn_count=1000 mod 2^CNT_W.
- Assert rst with 3 words in flight -> next cycle out_valid=0, busy=0, txn_count=0, in_ready=1; no stale word emerges afterwards.
- WIDTH=8, INC=1, input 0x0A -> output 0x26. CNT_W=4 with 17 transfers -> txn_count=1 (wrap).
